output_port_arbiter: RTL and testbench

- Downstream consumer of the router input-buffer FIFOs: one instance per router output port.
- Arbitrates round-robin among N_IN input buffers whose head flit is routed to this output port.
- Holds the grant for a whole wormhole packet, from head flit to tail flit.
- Tracks credits for the next hop's input buffer and forwards one flit per cycle on a registered output.

---
 rtl/output_port_arbiter.sv | 122 ++++++++++++
 tb/tb_output_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter for one router output
// port, with downstream credit tracking and a registered flit output.
module output_port_arbiter #(
    parameter  int N_IN       = 5,
    parameter  int DATA_WIDTH = 32,
    parameter  int CREDITS    = 5,
    localparam int CW         = $clog2(CREDITS) + 1,
    localparam int PW         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN-1:0]            req,
    input  logic [N_IN*DATA_WIDTH-1:0] flit_in,
    output logic [N_IN-1:0]            pop,
    output logic [DATA_WIDTH-1:0]      flit_out,
    output logic                       valid_out,
    input  logic                       credit_return,
    output logic [CW-1:0]              credits,
    output logic                       credit_overflow
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         owner;
    logic [N_IN-1:0]       is_head;
    logic [N_IN-1:0]       is_tail;
    logic [PW-1:0]         cand;
    logic                  found;
    logic [PW:0]           idx;
    logic [PW-1:0]         src;
    logic [PW-1:0]         src_next;
    logic                  go;
    logic                  tail_sent;
    logic [DATA_WIDTH-1:0] src_flit;

    // Decode the type field of each buffer's front flit (head/single, tail/single).
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            is_head[i] = flit_in[i*DATA_WIDTH + DATA_WIDTH - 2];
            is_tail[i] = flit_in[i*DATA_WIDTH + DATA_WIDTH - 1];
        end
    end

    // Round-robin search for a head/single request starting at rr_ptr.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_IN)) begin
                idx = idx - (PW+1)'(N_IN);
            end
            if (!found && req[idx[PW-1:0]] && is_head[idx[PW-1:0]]) begin
                found = 1'b1;
                cand  = idx[PW-1:0];
            end
        end
    end

    // Pick the source buffer and decide whether a flit moves this cycle.
    always_comb begin
        src = (state == LOCKED) ? owner : cand;
        go  = 1'b0;
        if (credits != '0) begin
            go = (state == LOCKED) ? req[owner] : found;
        end
        if (reset) begin
            go = 1'b0;
        end
        src_flit  = flit_in[src*DATA_WIDTH +: DATA_WIDTH];
        tail_sent = is_tail[src];
        src_next  = (src == PW'(N_IN - 1)) ? '0 : src + 1'b1;
        pop       = '0;
        pop[src]  = go;
    end

    // Packet-lock FSM, round-robin pointer, credit counter and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            credits         <= CW'(CREDITS);
            valid_out       <= 1'b0;
            flit_out        <= '0;
            credit_overflow <= 1'b0;
        end else begin
            valid_out <= go;
            if (go) begin
                flit_out <= src_flit;
                case (state)
                    IDLE: begin
                        if (tail_sent) begin
                            rr_ptr <= src_next;
                        end else begin
                            state <= LOCKED;
                            owner <= src;
                        end
                    end
                    LOCKED: begin
                        if (tail_sent) begin
                            state  <= IDLE;
                            rr_ptr <= src_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (go && !credit_return) begin
                credits <= credits - 1'b1;
            end else if (!go && credit_return) begin
                if (credits == CW'(CREDITS)) begin
                    credit_overflow <= 1'b1;
                end else begin
                    credits <= credits + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbiter model.
module tb_output_port_arbiter;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int C  = 5;
    localparam int CW = $clog2(C) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] flit_in;
    logic          credit_return;
    logic [N-1:0]  pop;
    logic [DW-1:0] flit_out;
    logic          valid_out;
    logic [CW-1:0] credits;
    logic          credit_overflow;

    always #5 clk = ~clk;

    output_port_arbiter #(.N_IN(N), .DATA_WIDTH(DW), .CREDITS(C)) dut (
        .clk(clk), .reset(reset), .req(req), .flit_in(flit_in),
        .pop(pop), .flit_out(flit_out), .valid_out(valid_out),
        .credit_return(credit_return), .credits(credits),
        .credit_overflow(credit_overflow)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [DW-1:0] fl [N];

    // behavioural model state
    bit            m_locked;
    int            m_owner, m_rr, m_credits;
    bit            m_ovf, m_valid;
    logic [DW-1:0] m_flit;
    int            e_sel;
    logic [N-1:0]  e_pop;

    // observed values
    logic [N-1:0]  o_pop;
    logic          o_valid, o_ovf;
    logic [DW-1:0] o_flit;
    logic [CW-1:0] o_cred;

    function automatic logic [DW-1:0] mk(input logic [1:0] t);
        logic [DW-3:0] p;
        p = (DW-2)'($urandom);
        return {t, p};
    endfunction

    function automatic logic [1:0] next_type(input logic [1:0] t);
        if (t == 2'b01 || t == 2'b00)
            return ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b00;
        return ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b01;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_credits = C;
        m_ovf = 0; m_valid = 0; m_flit = '0;
    endtask

    // One clock: drive, sample pop, step the model, sample registered outputs.
    task automatic cycle(input logic [N-1:0] r, input bit cr);
        logic [1:0] t;
        bit send;
        @(negedge clk);
        req = r;
        credit_return = cr;
        for (int i = 0; i < N; i++) flit_in[i*DW +: DW] = fl[i];
        #1;
        o_pop = pop;
        e_sel = -1;
        if (m_credits > 0) begin
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    t = fl[i][DW-1:DW-2];
                    if (e_sel < 0 && r[i] && (t == 2'b01 || t == 2'b11)) e_sel = i;
                end
            end else if (r[m_owner]) begin
                e_sel = m_owner;
            end
        end
        e_pop = '0;
        if (e_sel >= 0) e_pop[e_sel] = 1'b1;
        @(posedge clk);
        send = (e_sel >= 0);
        m_valid = send;
        if (send) begin
            m_flit = fl[e_sel];
            t = fl[e_sel][DW-1:DW-2];
            if (!m_locked) begin
                if (t == 2'b11) m_rr = (e_sel + 1) % N;
                else begin m_locked = 1; m_owner = e_sel; end
            end else if (t[1]) begin
                m_locked = 0;
                m_rr = (m_owner + 1) % N;
            end
        end
        if (send && !cr) m_credits--;
        else if (!send && cr) begin
            if (m_credits == C) m_ovf = 1;
            else m_credits++;
        end
        #1;
        o_valid = valid_out;
        o_flit  = flit_out;
        o_cred  = credits;
        o_ovf   = credit_overflow;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        credit_return = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            fl[i] = mk(2'b01);
            flit_in[i*DW +: DW] = fl[i];
        end
        req = '1;
        #1;
        n_cmp++; if (pop !== '0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", pop); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (credits !== CW'(C)) begin n_fail++; $display("FAIL reset_credits: got %0d want %0d", credits, C); end
        n_cmp++; if (credit_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", credit_overflow); end
        n_cmp++; if (flit_out !== '0) begin n_fail++; $display("FAIL reset_flit: got %h want 0", flit_out); end
        @(negedge clk);
        req = '0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        fl[0] = mk(2'b11);
        cycle(5'b00001, 1'b0);
        n_cmp++; if (o_pop !== 5'b00001) begin n_fail++; $display("FAIL single_pop: got %b want 00001", o_pop); end
        n_cmp++; if (o_valid !== 1'b1 || o_flit !== fl[0]) begin n_fail++; $display("FAIL single_out: got %b/%h want 1/%h", o_valid, o_flit, fl[0]); end
        n_cmp++; if (o_cred !== CW'(4)) begin n_fail++; $display("FAIL single_cred: got %0d want 4", o_cred); end
        fl[0] = mk(2'b11);
        fl[1] = mk(2'b11);
        cycle(5'b00011, 1'b0);
        n_cmp++; if (o_pop !== 5'b00010) begin n_fail++; $display("FAIL single_rr: got %b want 00010", o_pop); end
        cycle(5'b00000, 1'b0);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_packet();
        logic [1:0] seq [3];
        seq = '{2'b01, 2'b00, 2'b10};
        do_reset();
        fl[2] = mk(2'b01);
        for (int s = 0; s < 3; s++) begin
            fl[0] = mk(seq[s]);
            cycle(5'b00101, 1'b1);
            n_cmp++; if (o_pop !== 5'b00001) begin n_fail++; $display("FAIL pkt_lock%0d: got %b want 00001", s, o_pop); end
            n_cmp++; if (o_flit !== fl[0]) begin n_fail++; $display("FAIL pkt_flit%0d: got %h want %h", s, o_flit, fl[0]); end
        end
        fl[0] = mk(2'b01);
        cycle(5'b00101, 1'b1);
        n_cmp++; if (o_pop !== 5'b00100) begin n_fail++; $display("FAIL pkt_next: got %b want 00100", o_pop); end
        fl[2] = mk(2'b10);
        cycle(5'b00101, 1'b1);
        n_cmp++; if (o_pop !== 5'b00100) begin n_fail++; $display("FAIL pkt_tail2: got %b want 00100", o_pop); end
        n_cmp++; if (o_cred !== CW'(C)) begin n_fail++; $display("FAIL pkt_cred: got %0d want %0d", o_cred, C); end
    endtask

    task automatic test_credit_exhaust();
        int pops;
        do_reset();
        fl[1] = mk(2'b01);
        cycle(5'b00010, 1'b1);
        pops = 0;
        fl[1] = mk(2'b00);
        for (int s = 0; s < 7; s++) begin
            cycle(5'b00010, 1'b0);
            if (o_pop[1]) pops++;
        end
        n_cmp++; if (pops !== 5) begin n_fail++; $display("FAIL exh_pops: got %0d want 5", pops); end
        n_cmp++; if (o_pop !== '0 || o_cred !== '0) begin n_fail++; $display("FAIL exh_zero: got pop %b cred %0d want 0/0", o_pop, o_cred); end
        cycle(5'b00010, 1'b1);
        n_cmp++; if (o_pop !== '0 || o_cred !== CW'(1)) begin n_fail++; $display("FAIL exh_ret: got pop %b cred %0d want 0/1", o_pop, o_cred); end
        cycle(5'b00010, 1'b0);
        n_cmp++; if (o_pop !== 5'b00010 || o_valid !== 1'b1 || o_cred !== '0) begin n_fail++; $display("FAIL exh_resume: got pop %b v %b cred %0d want 00010/1/0", o_pop, o_valid, o_cred); end
    endtask

    task automatic test_credit_ovf();
        do_reset();
        fl[3] = mk(2'b11);
        cycle(5'b01000, 1'b0);
        cycle(5'b01000, 1'b0);
        cycle(5'b01000, 1'b1);
        n_cmp++; if (o_pop !== 5'b01000 || o_cred !== CW'(3)) begin n_fail++; $display("FAIL ovf_both: got pop %b cred %0d want 01000/3", o_pop, o_cred); end
        cycle(5'b00000, 1'b1);
        cycle(5'b00000, 1'b1);
        n_cmp++; if (o_cred !== CW'(5) || o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got cred %0d ovf %b want 5/0", o_cred, o_ovf); end
        cycle(5'b00000, 1'b1);
        n_cmp++; if (o_cred !== CW'(5) || o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got cred %0d ovf %b want 5/1", o_cred, o_ovf); end
        cycle(5'b01000, 1'b0);
        cycle(5'b00000, 1'b0);
        n_cmp++; if (o_ovf !== 1'b1 || o_cred !== CW'(4)) begin n_fail++; $display("FAIL ovf_sticky: got ovf %b cred %0d want 1/4", o_ovf, o_cred); end
    endtask

    task automatic test_bubble();
        do_reset();
        n_cmp++; if (credit_overflow !== 1'b0) begin n_fail++; $display("FAIL bub_ovfclr: got %b want 0", credit_overflow); end
        fl[4] = mk(2'b01);
        fl[1] = mk(2'b01);
        cycle(5'b10000, 1'b1);
        n_cmp++; if (o_pop !== 5'b10000) begin n_fail++; $display("FAIL bub_lock: got %b want 10000", o_pop); end
        for (int s = 0; s < 2; s++) begin
            cycle(5'b00010, 1'b1);
            n_cmp++; if (o_pop !== '0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL bub_gap%0d: got pop %b v %b want 0/0", s, o_pop, o_valid); end
        end
        fl[4] = mk(2'b10);
        cycle(5'b10010, 1'b1);
        n_cmp++; if (o_pop !== 5'b10000) begin n_fail++; $display("FAIL bub_tail: got %b want 10000", o_pop); end
        fl[4] = mk(2'b01);
        cycle(5'b10010, 1'b1);
        n_cmp++; if (o_pop !== 5'b00010) begin n_fail++; $display("FAIL bub_wrap: got %b want 00010", o_pop); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fl[0] = mk(2'b01);
        cycle(5'b00001, 1'b0);
        fl[0] = mk(2'b00);
        cycle(5'b00001, 1'b0);
        cycle(5'b00001, 1'b0);
        n_cmp++; if (o_cred !== CW'(2) || o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got cred %0d v %b want 2/1", o_cred, o_valid); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0 || pop !== '0 || credits !== CW'(C)) begin n_fail++; $display("FAIL mid_reset: got v %b pop %b cred %0d want 0/0/5", valid_out, pop, credits); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        fl[3] = mk(2'b01);
        cycle(5'b01001, 1'b0);
        n_cmp++; if (o_pop !== 5'b01000) begin n_fail++; $display("FAIL mid_after: got %b want 01000", o_pop); end
    endtask

    task automatic test_random();
        logic [1:0] ft [N];
        logic [N-1:0] r;
        do_reset();
        for (int i = 0; i < N; i++) begin
            ft[i] = next_type(2'b10);
            fl[i] = mk(ft[i]);
        end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) != 0);
            cycle(r, ($urandom_range(0, 99) < 40));
            n_cmp++; if (o_pop !== e_pop) begin n_fail++; $display("FAIL rnd_pop@%0d: got %b want %b", n, o_pop, e_pop); end
            n_cmp++; if (o_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", n, o_valid, m_valid); end
            n_cmp++; if (o_cred !== CW'(m_credits)) begin n_fail++; $display("FAIL rnd_cred@%0d: got %0d want %0d", n, o_cred, m_credits); end
            n_cmp++; if (o_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, o_ovf, m_ovf); end
            if (m_valid) begin
                n_cmp++; if (o_flit !== m_flit) begin n_fail++; $display("FAIL rnd_flit@%0d: got %h want %h", n, o_flit, m_flit); end
            end
            if (e_sel >= 0) begin
                ft[e_sel] = next_type(ft[e_sel]);
                fl[e_sel] = mk(ft[e_sel]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        credit_return = 1'b0;
        flit_in = '0;
        for (int i = 0; i < N; i++) fl[i] = '0;
        model_reset();
        test_reset();
        test_single();
        test_packet();
        test_credit_exhaust();
        test_credit_ovf();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
